// File: rtl/dds_voice_scheduler.sv
// Time-multiplexed DDS voice scheduler: one shared waveform generator serves all voices per sample frame.
// Optional build macro PHASE_SYNC_ON_GATE_EN: a gate 0->1 config write hard-syncs that voice's phase to 0.
module dds_voice_scheduler #(
   parameter int N_VOICES = 4,
   parameter int VID_W    = 2,
   parameter int PHASE_W  = 14,
   parameter int WAVE_W   = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sample_tick,
   input  logic                    cfg_we,
   input  logic [VID_W-1:0]        cfg_addr,
   input  logic [PHASE_W-1:0]      cfg_inc,
   input  logic                    cfg_gate,
   output logic [PHASE_W-1:0]      phase_out,
   output logic                    phase_valid,
   output logic [VID_W-1:0]        voice_id,
   input  logic [WAVE_W-1:0]       wave_in,
   output logic [WAVE_W+VID_W-1:0] mix_out,
   output logic                    mix_valid,
   output logic                    busy,
   output logic                    overrun
);
   localparam int MIX_W = WAVE_W + VID_W;

   typedef enum logic [1:0] {IDLE, STEP, SAMPLE, DONE} state_t;

   state_t             state_reg, state_next;
   logic [PHASE_W-1:0] phase_reg [N_VOICES];
   logic [PHASE_W-1:0] phase_next [N_VOICES];
   logic [PHASE_W-1:0] inc_reg [N_VOICES];
   logic [PHASE_W-1:0] inc_next [N_VOICES];
   logic [N_VOICES-1:0] gate_reg, gate_next;
   logic [VID_W-1:0]   idx_reg, idx_next;
   logic [MIX_W-1:0]   acc_reg, acc_next;
   logic [PHASE_W-1:0] phase_out_reg, phase_out_next;
   logic               phase_valid_reg, phase_valid_next;
   logic [VID_W-1:0]   voice_id_reg, voice_id_next;
   logic [MIX_W-1:0]   mix_out_reg, mix_out_next;
   logic               mix_valid_reg, mix_valid_next;
   logic               overrun_reg, overrun_next;
   logic [PHASE_W-1:0] stepped_phase;

   assign stepped_phase = phase_reg[idx_reg] + inc_reg[idx_reg];

   always_comb begin
      state_next       = state_reg;
      idx_next         = idx_reg;
      acc_next         = acc_reg;
      gate_next        = gate_reg;
      phase_out_next   = phase_out_reg;
      phase_valid_next = phase_valid_reg;
      voice_id_next    = voice_id_reg;
      mix_out_next     = mix_out_reg;
      mix_valid_next   = 1'b0;
      overrun_next     = overrun_reg;
      for (int i = 0; i < N_VOICES; i++) begin
         phase_next[i] = phase_reg[i];
         inc_next[i]   = inc_reg[i];
      end

      case (state_reg)
         IDLE: begin
            phase_valid_next = 1'b0;
            if (sample_tick) begin
               idx_next   = '0;
               acc_next   = '0;
               state_next = STEP;
            end
         end
         STEP: begin
            if (gate_reg[idx_reg]) begin
               phase_next[idx_reg] = stepped_phase;
               phase_out_next      = stepped_phase;
               phase_valid_next    = 1'b1;
            end else begin
               phase_out_next   = phase_reg[idx_reg];
               phase_valid_next = 1'b0;
            end
            voice_id_next = idx_reg;
            state_next    = SAMPLE;
         end
         SAMPLE: begin
            if (phase_valid_reg)
               acc_next = acc_reg + MIX_W'(wave_in);
            if (idx_reg == VID_W'(N_VOICES - 1)) begin
               state_next = DONE;
            end else begin
               idx_next   = idx_reg + 1'b1;
               state_next = STEP;
            end
         end
         DONE: begin
            mix_out_next     = acc_reg;
            mix_valid_next   = 1'b1;
            phase_valid_next = 1'b0;
            state_next       = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (sample_tick && state_reg != IDLE)
         overrun_next = 1'b1;

      // Config lands after the STEP update, so the sync clear overrides a same-cycle step.
      if (cfg_we) begin
         inc_next[cfg_addr]  = cfg_inc;
         gate_next[cfg_addr] = cfg_gate;
`ifdef PHASE_SYNC_ON_GATE_EN
         if (!gate_reg[cfg_addr] && cfg_gate)
            phase_next[cfg_addr] = '0;
`else
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         idx_reg         <= '0;
         acc_reg         <= '0;
         gate_reg        <= '0;
         phase_out_reg   <= '0;
         phase_valid_reg <= 1'b0;
         voice_id_reg    <= '0;
         mix_out_reg     <= '0;
         mix_valid_reg   <= 1'b0;
         overrun_reg     <= 1'b0;
         for (int i = 0; i < N_VOICES; i++) begin
            phase_reg[i] <= '0;
            inc_reg[i]   <= '0;
         end
      end else begin
         state_reg       <= state_next;
         idx_reg         <= idx_next;
         acc_reg         <= acc_next;
         gate_reg        <= gate_next;
         phase_out_reg   <= phase_out_next;
         phase_valid_reg <= phase_valid_next;
         voice_id_reg    <= voice_id_next;
         mix_out_reg     <= mix_out_next;
         mix_valid_reg   <= mix_valid_next;
         overrun_reg     <= overrun_next;
         for (int i = 0; i < N_VOICES; i++) begin
            phase_reg[i] <= phase_next[i];
            inc_reg[i]   <= inc_next[i];
         end
      end
   end

   assign phase_out   = phase_out_reg;
   assign phase_valid = phase_valid_reg;
   assign voice_id    = voice_id_reg;
   assign mix_out     = mix_out_reg;
   assign mix_valid   = mix_valid_reg;
   assign overrun     = overrun_reg;
   assign busy        = (state_reg != IDLE);
endmodule
